// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Brief    : Bit-serial A - B - Bin, LSB first, one cell plus registered borrow.
//            Define SERIAL_SUB_ADD_MODE_EN to add an op_add port (adder mode).
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
`ifdef SERIAL_SUB_ADD_MODE_EN
  input  logic             op_add,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int                 c_cnt_w    = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_diff;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_br;
  logic               r_bout;
  logic               r_ovf;
  logic               w_ai;
  logic               w_bi;
  logic               w_d;
  logic               w_br_nxt;
  logic               w_ovf;
  logic               w_last;

  assign w_ai   = r_a[0];
  assign w_bi   = r_b[0];
  assign w_d    = w_ai ^ w_bi ^ r_br;
  assign w_last = (r_cnt == c_cnt_last);

  // Overflow is evaluated on the final (MSB) bit, where w_d is diff[MSB].
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic r_add;
  assign w_br_nxt = r_add ? ((w_ai & w_bi) | (r_br & (w_ai ^ w_bi)))
                          : ((~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br));
  assign w_ovf    = r_add ? ((w_ai == w_bi) & (w_d != w_ai))
                          : ((w_ai != w_bi) & (w_d != w_ai));
`else
  assign w_br_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_br);
  assign w_ovf    = (w_ai != w_bi) & (w_d != w_ai);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_diff <= '0;
      r_cnt  <= '0;
      r_br   <= 1'b0;
      r_bout <= 1'b0;
      r_ovf  <= 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
      r_add  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= bin;
            r_cnt <= '0;
`ifdef SERIAL_SUB_ADD_MODE_EN
            r_add <= op_add;
`endif
          end
        end
        S_RUN: begin
          r_a    <= r_a >> 1;
          r_b    <= r_b >> 1;
          r_br   <= w_br_nxt;
          r_diff <= {w_d, r_diff[WIDTH-1:1]};
          r_cnt  <= r_cnt + c_cnt_one;
          if (w_last) begin
            r_bout <= w_br_nxt;
            r_ovf  <= w_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Brief    : Directed self-checking bench for serial_subtractor (WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;
  logic       ovf;
  logic       busy;
`ifdef SERIAL_SUB_ADD_MODE_EN
  logic       op_add;
`endif

  int ncomp = 0;
  int nfail = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
`ifdef SERIAL_SUB_ADD_MODE_EN
    .op_add    (op_add),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncomp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present operands, accept, and wait (bounded) for out_valid. Returns edge count.
  task automatic start_and_wait(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                                input logic tbin, input logic tadd, output int lat);
    a        = ta;
    b        = tb;
    bin      = tbin;
`ifdef SERIAL_SUB_ADD_MODE_EN
    op_add   = tadd;
`endif
    in_valid = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    cycle();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      cycle();
      lat++;
    end
    check({tag, "_latency"}, lat, 8);
    check({tag, "_busy"}, busy, 1'b1);
  endtask

  task automatic handshake(input string tag, input logic [7:0] ed);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check({tag, "_hs_out_valid"}, out_valid, 1'b0);
    check({tag, "_hs_in_ready"}, in_ready, 1'b1);
    check({tag, "_hs_diff_held"}, diff, ed);
  endtask

  task automatic do_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic tbin, input logic tadd,
                       input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    start_and_wait(tag, ta, tb, tbin, tadd, lat);
    check({tag, "_diff"}, diff, ed);
    check({tag, "_bout"}, bout, eb);
    check({tag, "_ovf"}, ovf, eo);
    handshake(tag, ed);
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    bin       = 1'b0;
`ifdef SERIAL_SUB_ADD_MODE_EN
    op_add    = 1'b0;
`endif
    cycle();
    cycle();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_diff", diff, 8'h00);
    check("rst_bout", bout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    rst_n = 1'b1;
    cycle();

    do_op("5m3",   8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
    do_op("3m5",   8'h03, 8'h05, 1'b0, 1'b0, 8'hFE, 1'b1, 1'b0);
    do_op("0m0b1", 8'h00, 8'h00, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    do_op("80m01", 8'h80, 8'h01, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1);
    do_op("7Fm FF", 8'h7F, 8'hFF, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1);
    do_op("A5m5Ab1", 8'hA5, 8'h5A, 1'b1, 1'b0, 8'h4A, 1'b0, 1'b1);

    // Back-pressure: hold DONE for 20 cycles while offering a new operand.
    start_and_wait("bp", 8'h10, 8'h01, 1'b0, 1'b0, lat);
    a        = 8'hEE;
    b        = 8'h11;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_diff", diff, 8'h0F);
      check("bp_bout", bout, 1'b0);
      check("bp_ovf", ovf, 1'b0);
    end
    in_valid = 1'b0;
    handshake("bp", 8'h0F);
    check("bp_idle_busy", busy, 1'b0);

    // Reset during RUN bit 4 aborts the operation.
    a        = 8'h33;
    b        = 8'h11;
    bin      = 1'b0;
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    cycle();
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_diff", diff, 8'h00);
    check("abort_bout", bout, 1'b0);
    rst_n = 1'b1;
    cycle();
    do_op("post_rst", 8'h01, 8'h02, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0);

`ifdef SERIAL_SUB_ADD_MODE_EN
    do_op("addFF01", 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    do_op("add7F01", 8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1);
    do_op("sub_after_add", 8'h05, 8'h03, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncomp, nfail);
    $finish;
  end

endmodule
`default_nettype wire
